// File: rtl/drt_enumerator.sv
// Wishbone master that walks the device ROM table: validates the header, then
// reads each 4-word entry and emits it as a device record on a valid/ready stream.
module drt_enumerator #(
    parameter logic [31:0] DRT_BASE_ADR    = 32'h0000_0000,
    parameter logic [15:0] EXPECTED_DRT_ID = 16'h0001,
    parameter int unsigned MAX_DEVICES     = 16,
    parameter int unsigned TIMEOUT         = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  err_code,
    output logic [15:0] num_devices,
    output logic [15:0] drt_version,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    output logic        dev_valid,
    input  logic        dev_ready,
    output logic [7:0]  dev_index,
    output logic [31:0] dev_id,
    output logic [31:0] dev_info,
    output logic [31:0] dev_mem_offset,
    output logic [31:0] dev_size
);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_GAP, EMIT, FINISH} state_t;

    state_t         state_q, state_d;
    logic [11:0]    word_idx_q, word_idx_d;
    logic [7:0]     dev_k_q, dev_k_d;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic           busy_q, busy_d, done_q, done_d, error_q, error_d;
    logic [1:0]     err_code_q, err_code_d;
    logic [15:0]    num_q, num_d, ver_q, ver_d, id_q, id_d;
    logic [31:0]    ent_q [4];
    logic [31:0]    ent_d [4];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            word_idx_q <= '0;
            dev_k_q    <= '0;
            tmo_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= '0;
            num_q      <= '0;
            ver_q      <= '0;
            id_q       <= '0;
            for (int unsigned i = 0; i < 4; i++) ent_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            word_idx_q <= word_idx_d;
            dev_k_q    <= dev_k_d;
            tmo_q      <= tmo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            err_code_q <= err_code_d;
            num_q      <= num_d;
            ver_q      <= ver_d;
            id_q       <= id_d;
            for (int unsigned i = 0; i < 4; i++) ent_q[i] <= ent_d[i];
        end
    end

    always_comb begin
        state_d    = state_q;
        word_idx_d = word_idx_q;
        dev_k_d    = dev_k_q;
        busy_d     = busy_q;
        done_d     = done_q;
        error_d    = error_q;
        err_code_d = err_code_q;
        num_d      = num_q;
        ver_d      = ver_q;
        id_d       = id_q;
        for (int unsigned i = 0; i < 4; i++) ent_d[i] = ent_q[i];

        case (state_q)
            IDLE: begin
                if (start) begin
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    err_code_d = '0;
                    num_d      = '0;
                    ver_d      = '0;
                    busy_d     = 1'b1;
                    word_idx_d = '0;
                    dev_k_d    = '0;
                    state_d    = RD_REQ;
                end
            end
            RD_REQ: begin
                if (wbm_ack_i) begin
                    if (word_idx_q == 12'd0) begin
                        id_d  = wbm_dat_i[31:16];
                        ver_d = wbm_dat_i[15:0];
                    end else if (word_idx_q == 12'd1) begin
                        num_d = wbm_dat_i[15:0];
                    end else begin
                        ent_d[word_idx_q[1:0]] = wbm_dat_i;
                    end
                    state_d = RD_GAP;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    state_d = IDLE; busy_d = 1'b0; error_d = 1'b1; err_code_d = 2'd1;
                end
            end
            RD_GAP: begin
                // The slave keeps ack high until it sees stb low; wait it out
                // before deciding, so a stale ack never completes the next read.
                if (!wbm_ack_i) begin
                    if (word_idx_q == 12'd0) begin
                        if (id_q != EXPECTED_DRT_ID) begin
                            state_d = IDLE; busy_d = 1'b0; error_d = 1'b1; err_code_d = 2'd2;
                        end else begin
                            word_idx_d = 12'd1;
                            state_d    = RD_REQ;
                        end
                    end else if (word_idx_q == 12'd1) begin
                        if (num_q > 16'(MAX_DEVICES)) begin
                            state_d = IDLE; busy_d = 1'b0; error_d = 1'b1; err_code_d = 2'd3;
                        end else if (num_q == 16'd0) begin
                            state_d = FINISH;
                        end else begin
                            word_idx_d = 12'd4;
                            state_d    = RD_REQ;
                        end
                    end else if (word_idx_q[1:0] == 2'd3) begin
                        state_d = EMIT;
                    end else begin
                        word_idx_d = word_idx_q + 12'd1;
                        state_d    = RD_REQ;
                    end
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    state_d = IDLE; busy_d = 1'b0; error_d = 1'b1; err_code_d = 2'd1;
                end
            end
            EMIT: begin
                if (dev_ready) begin
                    if ({8'd0, dev_k_q} + 16'd1 == num_q) begin
                        state_d = FINISH;
                    end else begin
                        dev_k_d    = dev_k_q + 8'd1;
                        word_idx_d = word_idx_q + 12'd1;
                        state_d    = RD_REQ;
                    end
                end
            end
            FINISH: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Restarts on every state change, so each bus phase gets its own budget.
    assign tmo_d = (state_d == state_q) ? tmo_q + TW'(1) : '0;

    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = error_q;
    assign err_code       = err_code_q;
    assign num_devices    = num_q;
    assign drt_version    = ver_q;
    assign wbm_cyc_o      = (state_q == RD_REQ);
    assign wbm_stb_o      = (state_q == RD_REQ);
    assign wbm_we_o       = 1'b0;
    assign wbm_sel_o      = 4'hF;
    assign wbm_adr_o      = DRT_BASE_ADR + {20'd0, word_idx_q};
    assign wbm_dat_o      = '0;
    assign dev_valid      = (state_q == EMIT);
    assign dev_index      = dev_k_q;
    assign dev_id         = ent_q[0];
    assign dev_info       = ent_q[1];
    assign dev_mem_offset = ent_q[2];
    assign dev_size       = ent_q[3];
endmodule

// File: tb/tb_drt_enumerator.sv
// Bench for drt_enumerator: table of DRT images, a reactive Wishbone slave, and
// a scoreboard of expected device records popped at each stream handshake.
module tb_drt_enumerator;
    localparam int TMO = 255;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, error;
    logic [1:0]  err_code;
    logic [15:0] num_devices, drt_version;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic [31:0] wbm_dat_i = '0;
    logic        wbm_ack_i = 1'b0;
    logic        dev_valid;
    logic        dev_ready = 1'b1;
    logic [7:0]  dev_index;
    logic [31:0] dev_id, dev_info, dev_mem_offset, dev_size;

    drt_enumerator #(
        .DRT_BASE_ADR(32'h0000_0000),
        .EXPECTED_DRT_ID(16'h0001),
        .MAX_DEVICES(16),
        .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .error(error),
        .err_code(err_code), .num_devices(num_devices), .drt_version(drt_version),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .dev_valid(dev_valid),
        .dev_ready(dev_ready), .dev_index(dev_index), .dev_id(dev_id),
        .dev_info(dev_info), .dev_mem_offset(dev_mem_offset), .dev_size(dev_size)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] w0, w1, stall;
        logic        done, err;
        logic [1:0]  code;
        logic [15:0] num, ver;
        int          nrec, nadr;
    } tc_t;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [31:0]   mem [16];
    logic [31:0]   stall_adr = 32'hFFFF_FFFF;
    logic [31:0]   adr_log [$];
    logic [135:0]  exp_q [$];
    logic [135:0]  dev_tab [2];
    int            nrec = 0;
    int            stall_cnt = 0;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Slave acks one cycle after a fresh strobe and drops ack once strobe falls.
    initial forever begin
        @(negedge clk);
        if (wbm_stb_o && wbm_adr_o == stall_adr) stall_cnt++;
        if (wbm_stb_o && !wbm_ack_i && wbm_adr_o != stall_adr) begin
            adr_log.push_back(wbm_adr_o);
            wbm_dat_i = mem[wbm_adr_o[3:0]];
            wbm_ack_i = 1'b1;
        end else if (!wbm_stb_o) begin
            wbm_ack_i = 1'b0;
        end
        if (dev_valid && dev_ready) begin
            nrec++;
            if (exp_q.size() == 0) check("unexpected_record", 160'(1), 160'(0));
            else check("record", 160'({dev_index, dev_id, dev_info, dev_mem_offset, dev_size}),
                       160'(exp_q.pop_front()));
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_end(input string name);
        int c;
        for (c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (done || error) break;
        end
        if (c >= 3000) check({name, "_end_timeout"}, 160'(0), 160'(1));
    endtask

    task automatic load(input logic [31:0] w0, input logic [31:0] w1);
        mem[0] = w0; mem[1] = w1; mem[2] = '0; mem[3] = '0;
        mem[4] = 32'h1EAF; mem[5] = 32'h1; mem[6] = 32'h100; mem[7] = 32'h40;
        mem[8] = 32'h2;    mem[9] = 32'h3; mem[10] = 32'h200; mem[11] = 32'h80;
        for (int i = 12; i < 16; i++) mem[i] = '0;
    endtask

    initial begin
        tc_t         tcs [6];
        logic [31:0] adr_seq [10];
        logic [135:0] held;
        logic        stable;
        int          base;

        adr_seq = '{32'd0, 32'd1, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd9, 32'd10, 32'd11};
        dev_tab[0] = {8'd0, 32'h1EAF, 32'h1, 32'h100, 32'h40};
        dev_tab[1] = {8'd1, 32'h2,    32'h3, 32'h200, 32'h80};
        //          w0            w1     stall         done  err   code  num    ver   nrec nadr
        tcs[0] = '{32'h00010001, 32'd2,  32'hFFFFFFFF, 1'b1, 1'b0, 2'd0, 16'd2,  16'd1, 2, 10};
        tcs[1] = '{32'h00010001, 32'd0,  32'hFFFFFFFF, 1'b1, 1'b0, 2'd0, 16'd0,  16'd1, 0, 2};
        tcs[2] = '{32'h00020001, 32'd2,  32'hFFFFFFFF, 1'b0, 1'b1, 2'd2, 16'd0,  16'd1, 0, 1};
        tcs[3] = '{32'h00010001, 32'd17, 32'hFFFFFFFF, 1'b0, 1'b1, 2'd3, 16'd17, 16'd1, 0, 2};
        tcs[4] = '{32'h00010001, 32'd2,  32'd5,        1'b0, 1'b1, 2'd1, 16'd2,  16'd1, 0, 3};
        tcs[5] = '{32'h00010003, 32'd1,  32'hFFFFFFFF, 1'b1, 1'b0, 2'd0, 16'd1,  16'd3, 1, 6};

        load(32'h00010001, 32'd2);
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctrl", 160'({busy, done, error, err_code, num_devices, drt_version,
                                  wbm_cyc_o, wbm_stb_o, wbm_adr_o, dev_valid}), 160'(0));
        check("reset_rec", 160'({dev_index, dev_id, dev_info, dev_mem_offset, dev_size}), 160'(0));
        rst = 1'b0;

        foreach (tcs[t]) begin
            load(tcs[t].w0, tcs[t].w1);
            stall_adr = tcs[t].stall;
            adr_log.delete();
            nrec = 0;
            stall_cnt = 0;
            for (int i = 0; i < tcs[t].nrec; i++) exp_q.push_back(dev_tab[i]);
            pulse_start();
            wait_end($sformatf("case%0d", t));
            @(negedge clk);
            check($sformatf("case%0d_status", t),
                  160'({busy, done, error, err_code, num_devices, drt_version}),
                  160'({1'b0, tcs[t].done, tcs[t].err, tcs[t].code, tcs[t].num, tcs[t].ver}));
            check($sformatf("case%0d_nrec", t), 160'(nrec), 160'(tcs[t].nrec));
            check($sformatf("case%0d_nadr", t), 160'(adr_log.size()), 160'(tcs[t].nadr));
            for (int i = 0; i < adr_log.size() && i < 10; i++)
                check($sformatf("case%0d_adr%0d", t, i), 160'(adr_log[i]), 160'(adr_seq[i]));
            check($sformatf("case%0d_cyc_idle", t), 160'({wbm_cyc_o, wbm_stb_o}), 160'(0));
            if (tcs[t].stall != 32'hFFFFFFFF)
                check("timeout_cycles", 160'(stall_cnt), 160'(TMO));
        end
        stall_adr = 32'hFFFF_FFFF;

        // Backpressure on record 0, with a start pulse that must be ignored.
        load(32'h00010001, 32'd2);
        adr_log.delete();
        nrec = 0;
        exp_q.push_back(dev_tab[0]);
        exp_q.push_back(dev_tab[1]);
        @(posedge clk); #1 dev_ready = 1'b0;
        pulse_start();
        for (base = 0; base < 200 && !dev_valid; base++) @(negedge clk);
        check("bp_valid_seen", 160'(dev_valid), 160'(1));
        held = {dev_index, dev_id, dev_info, dev_mem_offset, dev_size};
        check("bp_record0", 160'(held), 160'(dev_tab[0]));
        base = adr_log.size();
        stable = 1'b1;
        for (int c = 0; c < 50; c++) begin
            if (c == 10) begin
                @(posedge clk); #1 start = 1'b1;
                @(posedge clk); #1 start = 1'b0;
            end
            @(negedge clk);
            if (!dev_valid || wbm_cyc_o || !busy ||
                {dev_index, dev_id, dev_info, dev_mem_offset, dev_size} != held)
                stable = 1'b0;
        end
        check("bp_stable", 160'(stable), 160'(1));
        check("bp_no_bus", 160'(adr_log.size()), 160'(base));
        @(posedge clk); #1 dev_ready = 1'b1;
        wait_end("bp");
        @(negedge clk);
        check("bp_done", 160'({done, error, num_devices}), 160'({1'b1, 1'b0, 16'd2}));
        check("bp_nrec", 160'(nrec), 160'(2));
        check("bp_nadr", 160'(adr_log.size()), 160'(10));

        // Reset while a read request is outstanding.
        load(32'h00010001, 32'd2);
        stall_adr = 32'd5;
        pulse_start();
        for (base = 0; base < 200 && !(wbm_stb_o && wbm_adr_o == 32'd5); base++) @(negedge clk);
        check("rst_reached_req", 160'({wbm_stb_o, wbm_adr_o}), 160'({1'b1, 32'd5}));
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_ctrl", 160'({busy, done, error, err_code, num_devices, drt_version,
                                    wbm_cyc_o, wbm_stb_o, wbm_adr_o, dev_valid}), 160'(0));
        check("rst_mid_rec", 160'({dev_index, dev_id, dev_info, dev_mem_offset, dev_size}), 160'(0));
        rst = 1'b0;
        stall_adr = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
        check("scoreboard_empty", 160'(exp_q.size()), 160'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
